// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 5x4 active-low key matrix, debounces each key
// and queues press/release events in a 4-deep FIFO with valid/ready handshake.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [4:0]  btn_x,
    input  logic [3:0]  btn_y,
    output logic [19:0] key_state,
    output logic        event_valid,
    output logic [4:0]  event_code,
    output logic        event_press,
    input  logic        event_ready,
    output logic        overflow
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
    typedef enum logic {DWELL, UPDATE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [3:0] col_raw_q, col_raw_d;
    logic [3:0] y_meta_q, y_meta_d, y_sync_q, y_sync_d;
    logic [19:0] key_state_q, key_state_d;
    logic [19:0][3:0] deb_cnt_q, deb_cnt_d;
    logic [3:0][5:0] fifo_q, fifo_d;
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic overflow_q, overflow_d;
    logic [4:0] k;
    logic differs, flip, pop, do_push;
    always_comb begin
        y_meta_d = btn_y;
        y_sync_d = y_meta_q;
        k = {row_q, col_q};
        differs = col_raw_q[col_q] != key_state_q[k];
        flip = state_q == UPDATE && differs && deb_cnt_q[k] + 4'd1 == DEB;
        state_d = state_q;
        cnt_d = cnt_q;
        row_d = row_q;
        col_d = col_q;
        col_raw_d = col_raw_q;
        key_state_d = key_state_q;
        deb_cnt_d = deb_cnt_q;
        if (state_q == DWELL) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                col_raw_d = ~y_sync_q;
                col_d = 2'd0;
                state_d = UPDATE;
            end
        end else begin
            deb_cnt_d[k] = (flip || !differs) ? 4'd0 : deb_cnt_q[k] + 4'd1;
            key_state_d[k] = key_state_q[k] ^ flip;
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
                row_d = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
                cnt_d = '0;
                state_d = DWELL;
            end
        end
        // a pop in the same cycle frees a slot, so a full FIFO still accepts the push
        pop = count_q != 3'd0 && event_ready;
        do_push = flip && (count_q != 3'd4 || pop);
        fifo_d = fifo_q;
        if (do_push) fifo_d[wr_ptr_q] = {k, ~key_state_q[k]};
        wr_ptr_d = do_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d = count_q + {2'b00, do_push} - {2'b00, pop};
        overflow_d = overflow_q | (flip && !do_push);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DWELL;
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
            col_raw_q <= '0;
            y_meta_q <= 4'hF;
            y_sync_q <= 4'hF;
            key_state_q <= '0;
            deb_cnt_q <= '0;
            fifo_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            row_q <= row_d;
            col_q <= col_d;
            col_raw_q <= col_raw_d;
            y_meta_q <= y_meta_d;
            y_sync_q <= y_sync_d;
            key_state_q <= key_state_d;
            deb_cnt_q <= deb_cnt_d;
            fifo_q <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            overflow_q <= overflow_d;
        end
    end
    assign btn_x = ~(5'd1 << row_q);
    assign key_state = key_state_q;
    assign event_valid = count_q != 3'd0;
    assign {event_code, event_press} = fifo_q[rd_ptr_q];
    assign overflow = overflow_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: frame-level key/FIFO reference model driven by
// directed and random key patterns on a simulated 5x4 matrix.
module tb_keypad_matrix_scanner;
    localparam int SD = 8;
    localparam int DEB = 2;
    localparam int FRAME = 5 * (SD + 4);
    localparam int NF = 58;
    localparam logic [19:0] P5 = 20'h48421;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] btn_x;
    logic [3:0] btn_y;
    logic [19:0] key_state;
    logic event_valid;
    logic [4:0] event_code;
    logic event_press;
    logic event_ready = 1'b1;
    logic overflow;
    logic [19:0] pressed = '0;
    int n_chk = 0;
    int n_pass = 0;
    bit [19:0] ks_m;
    int dc_m [20];
    bit ovf_m;
    logic [5:0] mq [$];
    bit sv [61];
    logic [5:0] sc [61];
    logic [4:0] bx_e;

    keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_x(btn_x), .btn_y(btn_y),
        .key_state(key_state), .event_valid(event_valid), .event_code(event_code),
        .event_press(event_press), .event_ready(event_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always_comb begin
        btn_y = 4'hF;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++)
                if (!btn_x[r] && pressed[r*4+c]) btn_y[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // one sample per key per frame; an event lands on the UPDATE cycle of its key
    task automatic model_frame();
        for (int j = 0; j <= FRAME; j++) sv[j] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (pressed[k] != ks_m[k]) begin
                dc_m[k]++;
                if (dc_m[k] == DEB) begin
                    int j;
                    ks_m[k] = ~ks_m[k];
                    dc_m[k] = 0;
                    j = (SD + 4) * (k / 4) + SD + 1 + k % 4;
                    sv[j] = 1'b1;
                    sc[j] = {5'(k), ks_m[k]};
                end
            end else dc_m[k] = 0;
        end
    endtask

    function automatic logic ready_for(input int n, input int j);
        if (n >= 18) return $urandom_range(0, 3) != 0;
        if (n >= 11 && n <= 13) return 1'b0;
        if (n == 15 || n == 16) return n == 16 && j == FRAME - 1;
        return 1'b1;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1 pressed = 20'($urandom);
        end
        rst_n = 1'b0;
        pressed = '0;
        #1;
        check("rst_btn_x", 32'(btn_x), 32'h1E);
        check("rst_key_state", 32'(key_state), 32'h0);
        check("rst_event_valid", 32'(event_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < NF; n++) begin
            if (n >= 18) begin
                if ($urandom_range(0, 1) == 1) pressed = 20'($urandom & $urandom & $urandom);
            end else if (n == 1 || n == 2) pressed = 20'h00002;
            else if (n == 5) pressed = 20'h02000;
            else if (n == 7 || n == 8) pressed = 20'h90000;
            else if (n >= 11 && n <= 14) pressed = P5;
            else pressed = '0;
            model_frame();
            for (int j = 1; j <= FRAME; j++) begin
                event_ready = ready_for(n, j);
                @(posedge clk);
                #1;
                if (mq.size() != 0 && event_ready) void'(mq.pop_front());
                if (sv[j]) begin
                    if (mq.size() < 4) mq.push_back(sc[j]);
                    else ovf_m = 1'b1;
                end
                bx_e = ~(5'd1 << ((j == FRAME) ? 0 : j / (SD + 4)));
                check("btn_x", 32'(btn_x), 32'(bx_e));
                check("event_valid", 32'(event_valid), 32'(mq.size() != 0));
                if (mq.size() != 0) check("event_head", 32'({event_code, event_press}), 32'(mq[0]));
                if (j == FRAME) begin
                    check("key_state", 32'(key_state), 32'(ks_m));
                    check("overflow", 32'(overflow), 32'(ovf_m));
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
